// File: rtl/mips_io_responder.sv
// Device side of the 16-bit MIPS core I/O port: TX FIFO toward an external sink,
// RX FIFO from an external source, and a one-shot interrupt per RX data episode.
// Handshake: a word moves across a valid/ready pair on the rising clk edge where both are high;
// valid never waits on ready, and data is held stable while valid is high and ready is low.
module mips_io_responder #(
  parameter int DEPTH   = 4,
  parameter int INT_LEN = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] data_out,
  input  logic        out_valid,
  input  logic        in_ack,
  input  logic        int_en,
  output logic [15:0] data_in,
  output logic        in_avail,
  output logic        interrupt,
  output logic        tx_overflow,
  output logic [15:0] ext_tx_data,
  output logic        ext_tx_valid,
  input  logic        ext_tx_ready,
  input  logic [15:0] ext_rx_data,
  input  logic        ext_rx_valid,
  output logic        ext_rx_ready,
  output logic [1:0]  int_state
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int LW = (INT_LEN < 2) ? 1 : $clog2(INT_LEN + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ASSERT = 2'd1, WAIT = 2'd2} int_state_t;

  // ---------------- TX FIFO (core -> external sink) ----------------
  logic [15:0]   tx_mem [DEPTH];
  logic [PW-1:0] tx_wptr, tx_rptr;
  logic [CW-1:0] tx_count;
  logic          tx_full, tx_push, tx_pop;

  assign tx_full = (tx_count == CW'(DEPTH));
  assign tx_pop  = (tx_count != '0) && ext_tx_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the write.
  assign tx_push = out_valid && (!tx_full || tx_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_wptr     <= '0;
      tx_rptr     <= '0;
      tx_count    <= '0;
      tx_overflow <= 1'b0;
    end else begin
      if (tx_push) tx_wptr <= tx_wptr + PW'(1);
      if (tx_pop)  tx_rptr <= tx_rptr + PW'(1);
      if (tx_push && !tx_pop)      tx_count <= tx_count + CW'(1);
      else if (tx_pop && !tx_push) tx_count <= tx_count - CW'(1);
      if (out_valid && !tx_push)   tx_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wptr] <= data_out;
  end

  assign ext_tx_valid = (tx_count != '0);
  assign ext_tx_data  = ext_tx_valid ? tx_mem[tx_rptr] : 16'h0000;

  // ---------------- RX FIFO (external source -> core) ----------------
  logic [15:0]   rx_mem [DEPTH];
  logic [PW-1:0] rx_wptr, rx_rptr;
  logic [CW-1:0] rx_count;
  logic          rx_push, rx_pop;

  assign ext_rx_ready = (rx_count < CW'(DEPTH));
  assign rx_push      = ext_rx_valid && ext_rx_ready;
  assign rx_pop       = in_ack && (rx_count != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_wptr  <= '0;
      rx_rptr  <= '0;
      rx_count <= '0;
    end else begin
      if (rx_push) rx_wptr <= rx_wptr + PW'(1);
      if (rx_pop)  rx_rptr <= rx_rptr + PW'(1);
      if (rx_push && !rx_pop)      rx_count <= rx_count + CW'(1);
      else if (rx_pop && !rx_push) rx_count <= rx_count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wptr] <= ext_rx_data;
  end

  assign in_avail = (rx_count != '0);
  assign data_in  = in_avail ? rx_mem[rx_rptr] : 16'h0000;

  // ---------------- Interrupt FSM ----------------
  int_state_t    state_q, state_d;
  logic [LW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // WAIT holds off re-triggering until the RX FIFO has fully drained.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (int_en && (rx_count != '0)) begin
          state_d = ASSERT;
          cnt_d   = LW'(INT_LEN);
        end
      end
      ASSERT: begin
        cnt_d = cnt_q - LW'(1);
        if (!int_en || (cnt_q == LW'(1))) state_d = WAIT;
      end
      WAIT: begin
        if (rx_count == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign interrupt = (state_q == ASSERT);
  assign int_state = state_q;

endmodule
